// File: rtl/aes_spi_host_if.sv
// Host-side request/response and accelerator serial pins of aes_spi_host.
// master = the host controller, slave = whoever drives requests and models the accelerator.
interface aes_spi_host_if #(parameter int K = 256);
  logic         start;
  logic [7:0]   dir;
  logic [K-1:0] key;
  logic [127:0] text;
  logic         busy;
  logic [127:0] result;
  logic         valid;
  logic         err;
  logic         sck;
  logic         sdi;
  logic         load;
  logic         sdo;
  logic         done;

  modport master (input start, dir, key, text, sdo, done,
                  output busy, result, valid, err, sck, sdi, load);
  modport slave  (output start, dir, key, text, sdo, done,
                  input busy, result, valid, err, sck, sdi, load);
endinterface

// File: rtl/aes_spi_host.sv
// Serial host for an AES accelerator: shifts {text,key,dir} out MSB first,
// waits for done (with timeout), then shifts the 128-bit result back in.
module aes_spi_host #(
  parameter int K       = 256,
  parameter int CLKDIV  = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic           clk,
  input  logic           reset,
  aes_spi_host_if.master bus
);
  localparam int N  = K + 136;
  localparam int BW = $clog2(N);
  localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SHIFT_IN, WAIT_DONE, SHIFT_OUT} state_t;

  state_t        state, state_n;
  logic [N-1:0]  tx, tx_n;
  logic [126:0]  rx, rx_n;
  logic [127:0]  result_r, result_n;
  logic [BW-1:0] bit_cnt, bit_cnt_n;
  logic [DW-1:0] div_cnt, div_cnt_n;
  logic [TW-1:0] to_cnt, to_cnt_n;
  logic          sck_r, sdi_r, load_r, busy_r, valid_r, err_r;
  logic          sck_n, sdi_n, load_n, busy_n, valid_n, err_n;
  logic [1:0]    done_sync;
  logic          done_s, phase_end;

  assign done_s     = done_sync[1];
  assign phase_end  = (div_cnt == DIV_LAST);
  assign bus.sck    = sck_r;
  assign bus.sdi    = sdi_r;
  assign bus.load   = load_r;
  assign bus.busy   = busy_r;
  assign bus.valid  = valid_r;
  assign bus.err    = err_r;
  assign bus.result = result_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tx        <= '0;
      rx        <= '0;
      result_r  <= '0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      to_cnt    <= '0;
      sck_r     <= 1'b0;
      sdi_r     <= 1'b0;
      load_r    <= 1'b0;
      busy_r    <= 1'b0;
      valid_r   <= 1'b0;
      err_r     <= 1'b0;
      done_sync <= '0;
    end else begin
      state     <= state_n;
      tx        <= tx_n;
      rx        <= rx_n;
      result_r  <= result_n;
      bit_cnt   <= bit_cnt_n;
      div_cnt   <= div_cnt_n;
      to_cnt    <= to_cnt_n;
      sck_r     <= sck_n;
      sdi_r     <= sdi_n;
      load_r    <= load_n;
      busy_r    <= busy_n;
      valid_r   <= valid_n;
      err_r     <= err_n;
      done_sync <= {done_sync[0], bus.done};
    end
  end

  always_comb begin
    state_n   = state;
    tx_n      = tx;
    rx_n      = rx;
    result_n  = result_r;
    bit_cnt_n = bit_cnt;
    div_cnt_n = div_cnt;
    to_cnt_n  = to_cnt;
    sck_n     = sck_r;
    sdi_n     = sdi_r;
    load_n    = load_r;
    busy_n    = busy_r;
    valid_n   = 1'b0;
    err_n     = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        state_n   = SHIFT_IN;
        tx_n      = {bus.text, bus.key, bus.dir};
        sdi_n     = bus.text[127];
        load_n    = 1'b1;
        busy_n    = 1'b1;
        sck_n     = 1'b0;
        bit_cnt_n = BW'(N - 1);
        div_cnt_n = '0;
      end
      SHIFT_IN: begin
        div_cnt_n = phase_end ? '0 : div_cnt + 1'b1;
        if (phase_end) begin
          sck_n = ~sck_r;
          // End of a high phase: next bit goes out at the start of its low phase.
          if (sck_r) begin
            if (bit_cnt == '0) begin
              state_n  = WAIT_DONE;
              load_n   = 1'b0;
              sdi_n    = 1'b0;
              to_cnt_n = '0;
            end else begin
              tx_n      = tx << 1;
              sdi_n     = tx[N-2];
              bit_cnt_n = bit_cnt - 1'b1;
            end
          end
        end
      end
      WAIT_DONE: begin
        if (done_s) begin
          state_n   = SHIFT_OUT;
          bit_cnt_n = BW'(127);
          div_cnt_n = '0;
          sck_n     = 1'b0;
        end else if (to_cnt == TO_LAST) begin
          state_n = IDLE;
          err_n   = 1'b1;
          busy_n  = 1'b0;
        end else begin
          to_cnt_n = to_cnt + 1'b1;
        end
      end
      SHIFT_OUT: begin
        div_cnt_n = phase_end ? '0 : div_cnt + 1'b1;
        if (phase_end) begin
          sck_n = ~sck_r;
          if (sck_r) begin
            rx_n = {rx[125:0], bus.sdo};
            if (bit_cnt == '0) begin
              result_n = {rx, bus.sdo};
              state_n  = IDLE;
              valid_n  = 1'b1;
              busy_n   = 1'b0;
            end else begin
              bit_cnt_n = bit_cnt - 1'b1;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: doc/aes_spi_host.md
AES_SPI_HOST -- requirements
Module: aes_spi_host

Interface
REQ-001 Parameters: K, default 256, AES key width in bits (128, 192 or 256).
REQ-002 Parameters: CLKDIV, default 2, clk cycles per sck half-period (minimum 1).
REQ-003 Parameters: TIMEOUT, default 4096, maximum clk cycles to wait for done.
REQ-004 Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request one AES operation, accepted only in IDLE.
- dir  input  8  direction byte, sent last in the frame (0 = encrypt).
- key  input  K  AES key.
- text  input  128  input block (plaintext or ciphertext).
- busy  output  1  high from start acceptance until valid or err.
- result  output  128  last received output block.
- valid  output  1  one-cycle pulse when result updates.
- err  output  1  one-cycle pulse on done timeout.
- sck  output  1  serial clock to the accelerator.
- sdi  output  1  serial data to the accelerator.
- load  output  1  frame-load strobe to the accelerator.
- sdo  input  1  serial data from the accelerator.
- done  input  1  accelerator result-ready flag.
REQ-005 One clock domain: clk, with asynchronous active-high reset. done is asynchronous to clk and is synchronized internally.

Function
REQ-006 FSM states: IDLE, SHIFT_IN, WAIT_DONE, SHIFT_OUT.
REQ-007 In IDLE, start=1 at a clk edge latches frame = {text, key, dir} (N = K+136 bits) and enters SHIFT_IN. start while busy is ignored.
REQ-008 SHIFT_IN drives load=1 from the first cycle after acceptance.
- Bits are sent MSB first: frame[N-1] down to frame[0].
- Each bit takes CLKDIV cycles with sck=0, then CLKDIV cycles with sck=1.
- sdi changes only while sck=0, at the start of that bit's low phase.
REQ-009 Closing edge of the SHIFT_IN high phase for bit 0:
- sck=0 and load=0 on the same edge.
- Enter WAIT_DONE; SHIFT_IN therefore lasts exactly N*2*CLKDIV cycles.
REQ-010 done passes through a 2-flop synchronizer. In WAIT_DONE, synchronized done=1 enters SHIFT_OUT.
REQ-011 WAIT_DONE timeout: if synchronized done stays 0 for TIMEOUT cycles, pulse err for one cycle, clear busy, return to IDLE; result is unchanged.
REQ-012 SHIFT_OUT clocks 128 bits, each CLKDIV cycles sck=0 then CLKDIV cycles sck=1.
- sdo is sampled on the clk edge that ends each high phase.
- Each sample shifts into an internal register from the LSB, so the first bit received lands in result[127].
- sdi is held 0 and load is held 0.
REQ-013 Edge that ends the 128th high phase:
- The shift register is transferred to result.
- Next cycle: valid=1 for one cycle, busy=0, state=IDLE.
REQ-014 result holds its value until the next successful transfer.
REQ-015 Bit counters are sized for N (9 bits for K=256) and must not wrap within a frame.
REQ-016 sck is high only in SHIFT_IN and SHIFT_OUT high phases. No glitches: sck, sdi and load are registered outputs.
REQ-017 If start and the final valid-producing edge coincide, start is ignored because the FSM is not in IDLE on that edge.

Reset
REQ-018 reset=1 immediately forces:
- state=IDLE.
- sck=0, sdi=0, load=0, busy=0, valid=0, err=0, result=0.
- All counters and synchronizer flops cleared.
REQ-019 Reset mid-transfer aborts without a valid or err pulse. The first start after deassertion begins a fresh frame at bit N-1.

Verification
REQ-020 K=256, CLKDIV=2, device model = FIPS-197 C.3, dir=0, key=000102..1f, text=00112233445566778899aabbccddeeff -> result=8ea2b7ca516745bfeafc49904b496089, valid pulse, load high for exactly 392*4 cycles.
REQ-021 K=128, CLKDIV=1, dir=8'h01, text=3925841d02dc09fbdc118597196a0b32, key=2b7e151628aed2a6abf7158809cf4f3c -> captured frame bits equal {text,key,01}; result=3243f6a8885a308d313198a2e0370734.
REQ-022 start pulsed during SHIFT_IN and WAIT_DONE -> no restart; frame unchanged; exactly one valid pulse.
REQ-023 reset asserted at bit 100 of SHIFT_IN -> sck/load/busy 0 immediately; no valid; following start completes correctly.
REQ-024 done held 0, TIMEOUT=64 -> err pulses once 64 cycles after load falls; busy=0; result retains previous value.
